mcs4_rom_loader: RTL

- Upstream host-side stage that drives the MCS4_SYS ROM initialization port (ROM_INIT_ENB/ADDR/RE/WE/WDATA/RDATA) and the system reset_n.
- Consumes a byte stream (valid/ready, typically from a UART receiver) carrying Write, Read and Go commands.
- Holds the CPU in reset while it loads or dumps ROM, then releases it on Go.
- Read-back bytes are returned on a byte-stream output.

---
 rtl/mcs4_rom_loader_if.sv | 30 +++
 rtl/mcs4_rom_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mcs4_rom_loader_if.sv
// Byte-stream and ROM-init bus bundle for mcs4_rom_loader.
// master = loader side, slave = host/ROM/CPU side.
interface mcs4_rom_loader_if;
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   logic        RX_READY;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        CPU_RES_N;
   logic        ROM_INIT_ENB;
   logic [11:0] ROM_INIT_ADDR;
   logic        ROM_INIT_RE;
   logic        ROM_INIT_WE;
   logic [7:0]  ROM_INIT_WDATA;
   logic [7:0]  ROM_INIT_RDATA;
   logic        CMD_ERR;

   modport master (
      input  RX_DATA, RX_VALID, TX_READY, ROM_INIT_RDATA,
      output RX_READY, TX_DATA, TX_VALID, CPU_RES_N, ROM_INIT_ENB,
             ROM_INIT_ADDR, ROM_INIT_RE, ROM_INIT_WE, ROM_INIT_WDATA, CMD_ERR
   );

   modport slave (
      output RX_DATA, RX_VALID, TX_READY, ROM_INIT_RDATA,
      input  RX_READY, TX_DATA, TX_VALID, CPU_RES_N, ROM_INIT_ENB,
             ROM_INIT_ADDR, ROM_INIT_RE, ROM_INIT_WE, ROM_INIT_WDATA, CMD_ERR
   );
endinterface

// File: rtl/mcs4_rom_loader.sv
// Command-stream ROM loader for MCS4_SYS: W/R/G commands, holds CPU in reset while loading.
// Define MCS4_LOADER_CKSUM_EN to return a modulo-256 data checksum after each Write.
module mcs4_rom_loader #(
   parameter int unsigned ROM_RD_LAT = 1,
   parameter int unsigned BOOT_RUN   = 0
) (
   input logic               CLK,
   input logic               RES,
   mcs4_rom_loader_if.master bus
);

   localparam logic [7:0] CMD_W        = 8'h57;
   localparam logic [7:0] CMD_R        = 8'h52;
   localparam logic [7:0] CMD_G        = 8'h47;
   localparam logic [1:0] LAT          = 2'(ROM_RD_LAT);
   localparam logic       RUN_AT_RESET = (BOOT_RUN != 0);

   typedef enum logic [3:0] {
      IDLE, A_HI, A_LO, LEN, W_DATA, W_STB, R_ISSUE, R_WAIT, R_SEND
`ifdef MCS4_LOADER_CKSUM_EN
      , CK_SEND
`endif
   } state_t;

   state_t      st, nxt;
   logic        rx_ready, rx_fire, we, re, tx_valid, last;
   logic [11:0] addr;
   logic [8:0]  cnt;
   logic [7:0]  wdata, tx_data;
   logic [1:0]  lat_cnt;
   logic        is_wr, enb, cpu_res_n, cmd_err;
`ifdef MCS4_LOADER_CKSUM_EN
   logic [7:0]  cksum;
`endif

   assign last    = (cnt == 9'd1);
   assign rx_fire = rx_ready & bus.RX_VALID & ~RES;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) st <= IDLE;
      else     st <= nxt;
   end

   always_comb begin
      nxt      = st;
      rx_ready = 1'b0;
      we       = 1'b0;
      re       = 1'b0;
      tx_valid = 1'b0;
      case (st)
         IDLE: begin
            rx_ready = 1'b1;
            if (bus.RX_VALID && (bus.RX_DATA == CMD_W || bus.RX_DATA == CMD_R)) nxt = A_HI;
         end
         A_HI: begin
            rx_ready = 1'b1;
            if (bus.RX_VALID) nxt = A_LO;
         end
         A_LO: begin
            rx_ready = 1'b1;
            if (bus.RX_VALID) nxt = LEN;
         end
         LEN: begin
            rx_ready = 1'b1;
            if (bus.RX_VALID) nxt = is_wr ? W_DATA : R_ISSUE;
         end
         W_DATA: begin
            rx_ready = 1'b1;
            if (bus.RX_VALID) nxt = W_STB;
         end
         W_STB: begin
            we = 1'b1;
`ifdef MCS4_LOADER_CKSUM_EN
            nxt = last ? CK_SEND : W_DATA;
`else
            nxt = last ? IDLE : W_DATA;
`endif
         end
         R_ISSUE: begin
            re  = 1'b1;
            nxt = R_WAIT;
         end
         R_WAIT: begin
            if (lat_cnt == LAT) nxt = R_SEND;
         end
         R_SEND: begin
            tx_valid = 1'b1;
            if (bus.TX_READY) nxt = last ? IDLE : R_ISSUE;
         end
`ifdef MCS4_LOADER_CKSUM_EN
         CK_SEND: begin
            tx_valid = 1'b1;
            if (bus.TX_READY) nxt = IDLE;
         end
`endif
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         addr      <= '0;
         cnt       <= '0;
         wdata     <= '0;
         tx_data   <= '0;
         lat_cnt   <= '0;
         is_wr     <= 1'b0;
         cmd_err   <= 1'b0;
         enb       <= ~RUN_AT_RESET;
         cpu_res_n <= RUN_AT_RESET;
`ifdef MCS4_LOADER_CKSUM_EN
         cksum     <= '0;
`endif
      end else begin
         cmd_err <= 1'b0;
         case (st)
            IDLE: if (rx_fire) begin
               if (bus.RX_DATA == CMD_W || bus.RX_DATA == CMD_R) begin
                  is_wr     <= (bus.RX_DATA == CMD_W);
                  enb       <= 1'b1;
                  cpu_res_n <= 1'b0;
               end else if (bus.RX_DATA == CMD_G) begin
                  enb       <= 1'b0;
                  cpu_res_n <= 1'b1;
               end else begin
                  cmd_err   <= 1'b1;
               end
            end
            A_HI: if (rx_fire) addr[11:8] <= bus.RX_DATA[3:0];
            A_LO: if (rx_fire) addr[7:0] <= bus.RX_DATA;
            LEN: if (rx_fire) begin
               // a length byte of zero encodes 256 transfers
               cnt <= (bus.RX_DATA == 8'h00) ? 9'd256 : {1'b0, bus.RX_DATA};
`ifdef MCS4_LOADER_CKSUM_EN
               cksum <= '0;
`endif
            end
            W_DATA: if (rx_fire) begin
               wdata <= bus.RX_DATA;
`ifdef MCS4_LOADER_CKSUM_EN
               cksum <= cksum + bus.RX_DATA;
`endif
            end
            W_STB: begin
               addr <= addr + 12'd1;
               cnt  <= cnt - 9'd1;
`ifdef MCS4_LOADER_CKSUM_EN
               if (last) tx_data <= cksum;
`endif
            end
            R_ISSUE: lat_cnt <= 2'd1;
            R_WAIT: begin
               if (lat_cnt == LAT) tx_data <= bus.ROM_INIT_RDATA;
               else                lat_cnt <= lat_cnt + 2'd1;
            end
            R_SEND: if (bus.TX_READY) begin
               addr <= addr + 12'd1;
               cnt  <= cnt - 9'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.RX_READY       = rx_ready & ~RES;
   assign bus.TX_DATA        = tx_data;
   assign bus.TX_VALID       = tx_valid;
   assign bus.CPU_RES_N      = cpu_res_n;
   assign bus.ROM_INIT_ENB   = enb;
   assign bus.ROM_INIT_ADDR  = addr;
   assign bus.ROM_INIT_RE    = re & enb;
   assign bus.ROM_INIT_WE    = we & enb;
   assign bus.ROM_INIT_WDATA = wdata;
   assign bus.CMD_ERR        = cmd_err;

endmodule
